addr_trans_stage: RTL and testbench

ADDR_TRANS_STAGE -- requirements
Module: addr_trans_stage

---
 rtl/mmu_pkg.sv | 30 +++
 rtl/dmw_match.sv | 37 +++
 rtl/addr_trans_stage.sv | 170 +++++++++++++++++
 tb/tb_addr_trans_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
`default_nettype none
// =============================================================================
// mmu_pkg : exception codes, page-size constants and DMW field layout
// Rev 1.0
// =============================================================================
package mmu_pkg;

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_TLBR = 3'd1,
    EXC_PIL  = 3'd2,
    EXC_PIS  = 3'd3,
    EXC_PPI  = 3'd4,
    EXC_PME  = 3'd5
  } exc_e;

  localparam logic [5:0] c_PS_4K = 6'd12;
  localparam logic [5:0] c_PS_4M = 6'd22;

  localparam int unsigned c_DMW_PLV0     = 0;
  localparam int unsigned c_DMW_PLV3     = 3;
  localparam int unsigned c_DMW_MAT_LSB  = 4;
  localparam int unsigned c_DMW_MAT_MSB  = 5;
  localparam int unsigned c_DMW_PSEG_LSB = 25;
  localparam int unsigned c_DMW_PSEG_MSB = 27;
  localparam int unsigned c_DMW_VSEG_LSB = 29;
  localparam int unsigned c_DMW_VSEG_MSB = 31;

endpackage
`default_nettype wire

// File: rtl/dmw_match.sv
`default_nettype none
// =============================================================================
// dmw_match : single direct-map window hit check and physical segment select
// Rev 1.0
// =============================================================================
module dmw_match
  import mmu_pkg::*;
(
  input  logic [31:0] dmw,
  input  logic [2:0]  va_seg,
  input  logic [1:0]  plv,
  output logic        hit,
  output logic [2:0]  pseg,
  output logic [1:0]  mat
);

  logic w_plv_ok;

  // Only PLV0 and PLV3 have enable bits; PLV1/2 can never use a window.
  always_comb begin
    w_plv_ok = 1'b0;
    case (plv)
      2'd0:    w_plv_ok = dmw[c_DMW_PLV0];
      2'd3:    w_plv_ok = dmw[c_DMW_PLV3];
      default: w_plv_ok = 1'b0;
    endcase
  end

  assign hit  = w_plv_ok && (va_seg == dmw[c_DMW_VSEG_MSB:c_DMW_VSEG_LSB]);
  assign pseg = dmw[c_DMW_PSEG_MSB:c_DMW_PSEG_LSB];
  assign mat  = dmw[c_DMW_MAT_MSB:c_DMW_MAT_LSB];

  logic w_unused_dmw;
  assign w_unused_dmw = ^{dmw[2:1], dmw[24:6], dmw[28]};

endmodule
`default_nettype wire

// File: rtl/addr_trans_stage.sv
`default_nettype none
// =============================================================================
// addr_trans_stage : load/store VA->PA translation (DA, DMW, TLB) with hold
// Rev 1.0
// =============================================================================
module addr_trans_stage
  import mmu_pkg::*;
#(
  parameter int TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_va,
  input  logic                      req_store,
  input  logic                      csr_crmd_da,
  input  logic                      csr_crmd_pg,
  input  logic [1:0]                csr_crmd_plv,
  input  logic [1:0]                csr_crmd_datm,
  input  logic [9:0]                csr_asid,
  input  logic [31:0]               csr_dmw0,
  input  logic [31:0]               csr_dmw1,
  output logic [18:0]               s_vppn,
  output logic                      s_va_bit12,
  output logic [9:0]                s_asid,
  input  logic                      s_found,
  input  logic [$clog2(TLBNUM)-1:0] s_index,
  input  logic [19:0]               s_ppn,
  input  logic [5:0]                s_ps,
  input  logic [1:0]                s_plv,
  input  logic [1:0]                s_mat,
  input  logic                      s_d,
  input  logic                      s_v,
  input  logic                      flush,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_pa,
  output logic [1:0]                resp_mat,
  output logic [2:0]                resp_exc,
  output logic [31:0]               resp_badv
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e      r_state;
  logic [31:0] r_va;
  logic        r_store, r_da, r_pg;
  logic [1:0]  r_plv, r_datm;
  logic [9:0]  r_asid;
  logic [31:0] r_dmw0, r_dmw1;

  logic        w_accept;
  logic        w_dmw0_hit, w_dmw1_hit;
  logic [2:0]  w_dmw0_pseg, w_dmw1_pseg;
  logic [1:0]  w_dmw0_mat, w_dmw1_mat;
  logic [31:0] w_pa;
  logic [1:0]  w_mat;
  exc_e        w_exc;

  assign req_ready  = !flush && ((r_state == S_IDLE) || ((r_state == S_HOLD) && resp_ready));
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == S_HOLD);

  assign s_vppn     = (r_state == S_LOOKUP) ? r_va[31:13] : 19'd0;
  assign s_va_bit12 = (r_state == S_LOOKUP) ? r_va[12]    : 1'b0;
  assign s_asid     = (r_state == S_LOOKUP) ? r_asid      : 10'd0;

  dmw_match u_dmw0 (
    .dmw    (r_dmw0),
    .va_seg (r_va[31:29]),
    .plv    (r_plv),
    .hit    (w_dmw0_hit),
    .pseg   (w_dmw0_pseg),
    .mat    (w_dmw0_mat)
  );

  dmw_match u_dmw1 (
    .dmw    (r_dmw1),
    .va_seg (r_va[31:29]),
    .plv    (r_plv),
    .hit    (w_dmw1_hit),
    .pseg   (w_dmw1_pseg),
    .mat    (w_dmw1_mat)
  );

  // Anything not in direct-address mode is treated as paged.
  always_comb begin
    w_pa  = 32'd0;
    w_mat = 2'd0;
    w_exc = EXC_NONE;
    if (r_da) begin
      w_pa  = r_va;
      w_mat = r_datm;
    end else if (w_dmw0_hit) begin
      w_pa  = {w_dmw0_pseg, r_va[28:0]};
      w_mat = w_dmw0_mat;
    end else if (w_dmw1_hit) begin
      w_pa  = {w_dmw1_pseg, r_va[28:0]};
      w_mat = w_dmw1_mat;
    end else begin
      if (!s_found)                w_exc = EXC_TLBR;
      else if (!s_v)               w_exc = r_store ? EXC_PIS : EXC_PIL;
      else if (r_plv > s_plv)      w_exc = EXC_PPI;
      else if (r_store && !s_d)    w_exc = EXC_PME;
      if (w_exc == EXC_NONE) begin
        w_mat = s_mat;
        w_pa  = (s_ps == c_PS_4M) ? {s_ppn[19:10], r_va[21:0]} : {s_ppn, r_va[11:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_va      <= 32'd0;
      r_store   <= 1'b0;
      r_da      <= 1'b0;
      r_pg      <= 1'b0;
      r_plv     <= 2'd0;
      r_datm    <= 2'd0;
      r_asid    <= 10'd0;
      r_dmw0    <= 32'd0;
      r_dmw1    <= 32'd0;
      resp_pa   <= 32'd0;
      resp_mat  <= 2'd0;
      resp_exc  <= EXC_NONE;
      resp_badv <= 32'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      if (w_accept) begin
        r_va    <= req_va;
        r_store <= req_store;
        r_da    <= csr_crmd_da;
        r_pg    <= csr_crmd_pg;
        r_plv   <= csr_crmd_plv;
        r_datm  <= csr_crmd_datm;
        r_asid  <= csr_asid;
        r_dmw0  <= csr_dmw0;
        r_dmw1  <= csr_dmw1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          resp_pa   <= w_pa;
          resp_mat  <= w_mat;
          resp_exc  <= w_exc;
          resp_badv <= r_va;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (resp_ready) r_state <= req_valid ? S_LOOKUP : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_unused_top;
  assign w_unused_top = ^{r_pg, s_index};

endmodule
`default_nettype wire

// File: tb/tb_addr_trans_stage.sv
`default_nettype none
// =============================================================================
// tb_addr_trans_stage : directed + randomized checks against a reference model
// Rev 1.0
// =============================================================================
module tb_addr_trans_stage;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [31:0] req_va = 32'd0;
  logic        csr_crmd_da = 1'b0, csr_crmd_pg = 1'b0;
  logic [1:0]  csr_crmd_plv = 2'd0, csr_crmd_datm = 2'd0;
  logic [9:0]  csr_asid = 10'd0;
  logic [31:0] csr_dmw0 = 32'd0, csr_dmw1 = 32'd0;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found = 1'b0, s_d = 1'b0, s_v = 1'b0;
  logic [3:0]  s_index = 4'd0;
  logic [19:0] s_ppn = 20'd0;
  logic [5:0]  s_ps = 6'd12;
  logic [1:0]  s_plv = 2'd0, s_mat = 2'd0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_pa, resp_badv;
  logic [1:0]  resp_mat;
  logic [2:0]  resp_exc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addr_trans_stage #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_store(req_store),
    .csr_crmd_da(csr_crmd_da), .csr_crmd_pg(csr_crmd_pg), .csr_crmd_plv(csr_crmd_plv),
    .csr_crmd_datm(csr_crmd_datm), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv),
    .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_pa(resp_pa), .resp_mat(resp_mat), .resp_exc(resp_exc), .resp_badv(resp_badv)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference translation: returns {exc, mat, pa}
  function automatic logic [36:0] model(
    input logic [31:0] va, input logic st, input logic da, input logic [1:0] plv,
    input logic [1:0] datm, input logic [31:0] d0, input logic [31:0] d1,
    input logic f, input logic [19:0] ppn, input logic [5:0] ps,
    input logic [1:0] splv, input logic [1:0] smat, input logic sd, input logic sv);
    logic [31:0] dm [2];
    logic [31:0] pa;
    logic [2:0]  e;
    logic        plv_ok;
    if (da) return {3'd0, datm, va};
    dm[0] = d0;
    dm[1] = d1;
    for (int w = 0; w < 2; w++) begin
      plv_ok = (plv == 2'd0 && dm[w][0]) || (plv == 2'd3 && dm[w][3]);
      if (plv_ok && va[31:29] == dm[w][31:29]) begin
        pa = (32'(dm[w][27:25]) << 29) | (va & 32'h1FFF_FFFF);
        return {3'd0, dm[w][5:4], pa};
      end
    end
    if (!f)                    e = 3'd1;
    else if (!sv)              e = st ? 3'd3 : 3'd2;
    else if (plv > splv)       e = 3'd4;
    else if (st && !sd)        e = 3'd5;
    else                       e = 3'd0;
    if (e != 3'd0) return {e, 2'd0, 32'd0};
    if (ps == 6'd22) pa = ((32'(ppn) >> 10) << 22) | (va & 32'h003F_FFFF);
    else             pa = (32'(ppn) << 12) | (va & 32'h0000_0FFF);
    return {3'd0, smat, pa};
  endfunction

  // One request end to end; CSRs are scrambled right after acceptance.
  task automatic xact(input logic [31:0] va, input logic st,
                      output logic [36:0] res, output logic [31:0] badv,
                      output logic [29:0] lk, output int lat);
    logic [31:0] k_dmw0, k_dmw1;
    logic        k_da, k_pg;
    logic [1:0]  k_plv, k_datm;
    logic [9:0]  k_asid;
    int          guard;
    guard = 0;
    req_va = va; req_store = st; req_valid = 1'b1; resp_ready = 1'b0;
    #1;
    while (!req_ready && guard < 20) begin tick; guard++; end
    tick;
    req_valid = 1'b0;
    req_va = $urandom;
    lk = {s_vppn, s_va_bit12, s_asid};
    k_dmw0 = csr_dmw0; k_dmw1 = csr_dmw1; k_da = csr_crmd_da; k_pg = csr_crmd_pg;
    k_plv = csr_crmd_plv; k_datm = csr_crmd_datm; k_asid = csr_asid;
    csr_dmw0 = $urandom; csr_dmw1 = $urandom; csr_crmd_da = ~k_da; csr_crmd_pg = ~k_pg;
    csr_crmd_plv = ~k_plv; csr_crmd_datm = ~k_datm; csr_asid = ~k_asid;
    lat = 1;
    while (!resp_valid && lat < 10) begin tick; lat++; end
    res  = {resp_exc, resp_mat, resp_pa};
    badv = resp_badv;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    csr_dmw0 = k_dmw0; csr_dmw1 = k_dmw1; csr_crmd_da = k_da; csr_crmd_pg = k_pg;
    csr_crmd_plv = k_plv; csr_crmd_datm = k_datm; csr_asid = k_asid;
  endtask

  task automatic set_tlb(input logic f, input logic [19:0] ppn, input logic [5:0] ps,
                         input logic [1:0] splv, input logic [1:0] smat, input logic sd, input logic sv);
    s_found = f; s_ppn = ppn; s_ps = ps; s_plv = splv; s_mat = smat; s_d = sd; s_v = sv;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    n_tests++;
    if ({resp_valid, resp_pa, resp_mat, resp_exc, resp_badv, s_vppn} !== 88'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b pa=%h mat=%h exc=%h badv=%h vppn=%h required all zero",
               resp_valid, resp_pa, resp_mat, resp_exc, resp_badv, s_vppn);
    end
    tick;
    resetn = 1'b1;
    tick;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b valid=%b required ready=1 valid=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_da;
    logic [36:0] res; logic [31:0] badv; logic [29:0] lk; int lat;
    csr_crmd_da = 1'b1; csr_crmd_pg = 1'b0; csr_crmd_datm = 2'd1; csr_asid = 10'h155;
    xact(32'h1C00_1234, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL da_latency: got %0d required 2", lat); end
    n_tests++;
    if (res !== {3'd0, 2'd1, 32'h1C00_1234} || badv !== 32'h1C00_1234) begin
      n_fail++; $display("FAIL da_result: got %h badv %h required %h badv 1c001234", res, badv, {3'd0, 2'd1, 32'h1C00_1234});
    end
    n_tests++;
    if (lk !== {19'h0E000, 1'b1, 10'h155}) begin
      n_fail++; $display("FAIL da_lookup_drive: got %h required %h", lk, {19'h0E000, 1'b1, 10'h155});
    end
  endtask

  task automatic test_dmw;
    logic [36:0] res; logic [31:0] badv; logic [29:0] lk; int lat;
    csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd0;
    csr_dmw0 = 32'h8000_0011; csr_dmw1 = 32'd0;
    set_tlb(1'b1, 20'h00ABC, 6'd12, 2'd3, 2'd2, 1'b1, 1'b1);
    xact(32'h8000_1000, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res !== {3'd0, 2'd1, 32'h0000_1000}) begin
      n_fail++; $display("FAIL dmw_hit_plv0: got %h required %h", res, {3'd0, 2'd1, 32'h0000_1000});
    end
    csr_crmd_plv = 2'd3;
    xact(32'h8000_1000, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res !== {3'd0, 2'd2, 32'h00AB_C000}) begin
      n_fail++; $display("FAIL dmw_miss_plv3_tlb: got %h required %h", res, {3'd0, 2'd2, 32'h00AB_C000});
    end
  endtask

  task automatic test_tlb;
    logic [36:0] res; logic [31:0] badv; logic [29:0] lk; int lat;
    csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd0; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0;
    set_tlb(1'b1, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b1, 1'b1);
    xact(32'h0040_0ABC, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res !== {3'd0, 2'd1, 32'h1234_5ABC}) begin
      n_fail++; $display("FAIL tlb_4k: got %h required %h", res, {3'd0, 2'd1, 32'h1234_5ABC});
    end
    s_ps = 6'd22;
    xact(32'h0040_0ABC, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res !== {3'd0, 2'd1, 32'h1200_0ABC}) begin
      n_fail++; $display("FAIL tlb_4m: got %h required %h", res, {3'd0, 2'd1, 32'h1200_0ABC});
    end
    s_ps = 6'd12; s_found = 1'b0;
    xact(32'h0040_0ABC, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res !== {EXC_TLBR, 2'd0, 32'd0} || badv !== 32'h0040_0ABC) begin
      n_fail++; $display("FAIL tlb_refill: got %h badv %h required %h badv 00400abc", res, badv, {EXC_TLBR, 2'd0, 32'd0});
    end
  endtask

  task automatic test_exc_priority;
    logic [36:0] res; logic [31:0] badv; logic [29:0] lk; int lat;
    csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd3; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0;
    set_tlb(1'b1, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1);
    xact(32'h0040_0ABC, 1'b1, res, badv, lk, lat);
    n_tests++;
    if (res[36:34] !== EXC_PPI || res[33:0] !== 34'd0) begin
      n_fail++; $display("FAIL exc_ppi: got %h required exc=4 pa=0 mat=0", res);
    end
    s_plv = 2'd3;
    xact(32'h0040_0ABC, 1'b1, res, badv, lk, lat);
    n_tests++;
    if (res[36:34] !== EXC_PME || res[33:0] !== 34'd0) begin
      n_fail++; $display("FAIL exc_pme: got %h required exc=5 pa=0 mat=0", res);
    end
    s_v = 1'b0;
    xact(32'h0040_0ABC, 1'b1, res, badv, lk, lat);
    n_tests++;
    if (res[36:34] !== EXC_PIS) begin n_fail++; $display("FAIL exc_pis: got exc %h required 3", res[36:34]); end
    xact(32'h0040_0ABC, 1'b0, res, badv, lk, lat);
    n_tests++;
    if (res[36:34] !== EXC_PIL) begin n_fail++; $display("FAIL exc_pil: got exc %h required 2", res[36:34]); end
  endtask

  task automatic test_backpressure_flush;
    logic [68:0] exp_out;
    csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd0; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0;
    set_tlb(1'b1, 20'hAAAAA, 6'd12, 2'd0, 2'd2, 1'b1, 1'b1);
    exp_out = {32'hAAAA_A234, 2'd2, 3'd0, 32'h0040_3234};
    req_va = 32'h0040_3234; req_store = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      set_tlb($urandom_range(0, 1), 20'($urandom), 6'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      req_valid = 1'b1;
      tick;
      n_tests++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {resp_pa, resp_mat, resp_exc, resp_badv} !== exp_out) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b ready=%b out=%h required valid=1 ready=0 out=%h",
                 i, resp_valid, req_ready, {resp_pa, resp_mat, resp_exc, resp_badv}, exp_out);
      end
    end
    resp_ready = 1'b1; flush = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b required 0", req_ready); end
    tick;
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    n_tests++;
    if (resp_valid !== 1'b0 || s_vppn !== 19'd0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle: got valid=%b vppn=%h ready=%b required 0 0 1", resp_valid, s_vppn, req_ready);
    end
    tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_resp: got valid=%b required 0", resp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [36:0] exp_a, exp_b;
    csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd0; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0;
    set_tlb(1'b1, 20'h54321, 6'd12, 2'd0, 2'd3, 1'b1, 1'b1);
    exp_a = model(32'h0000_5111, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 20'h54321, 6'd12, 2'd0, 2'd3, 1'b1, 1'b1);
    exp_b = model(32'h0123_6222, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 20'h54321, 6'd12, 2'd0, 2'd3, 1'b1, 1'b1);
    req_va = 32'h0000_5111; req_store = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
    tick;
    req_va = 32'h0123_6222; req_store = 1'b1;
    tick;
    n_tests++;
    if (resp_valid !== 1'b1 || {resp_exc, resp_mat, resp_pa} !== exp_a) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b %h required %h", resp_valid, {resp_exc, resp_mat, resp_pa}, exp_a);
    end
    resp_ready = 1'b1;
    tick;
    req_valid = 1'b0; resp_ready = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || s_vppn !== 19'h0091B) begin
      n_fail++; $display("FAIL b2b_lookup: got valid=%b vppn=%h required 0 0091b", resp_valid, s_vppn);
    end
    tick;
    n_tests++;
    if (resp_valid !== 1'b1 || {resp_exc, resp_mat, resp_pa} !== exp_b || resp_badv !== 32'h0123_6222) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b %h badv %h required %h", resp_valid, {resp_exc, resp_mat, resp_pa}, resp_badv, exp_b);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight;
    req_va = 32'hDEAD_B000; req_valid = 1'b1; resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    resetn = 1'b0;
    #2;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_badv !== 32'd0 || s_vppn !== 19'd0) begin
      n_fail++; $display("FAIL reset_async: got valid=%b badv=%h vppn=%h required all zero", resp_valid, resp_badv, s_vppn);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_drop[%0d]: got valid=%b ready=%b required 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_random;
    logic [36:0] res, exp_res; logic [31:0] badv, va; logic [29:0] lk; int lat; logic st;
    for (int i = 0; i < 80; i++) begin
      va = $urandom; st = 1'($urandom);
      csr_crmd_da = ($urandom_range(0, 3) == 0); csr_crmd_pg = ~csr_crmd_da;
      csr_crmd_plv = 2'($urandom); csr_crmd_datm = 2'($urandom); csr_asid = 10'($urandom);
      csr_dmw0 = $urandom; csr_dmw1 = $urandom;
      if ($urandom_range(0, 1) == 1) csr_dmw0[31:29] = va[31:29];
      if ($urandom_range(0, 1) == 1) csr_dmw1[31:29] = va[31:29];
      set_tlb($urandom_range(0, 6) != 0, 20'($urandom), ($urandom_range(0, 1) == 1) ? 6'd22 : 6'd12,
              2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 6) != 0);
      exp_res = model(va, st, csr_crmd_da, csr_crmd_plv, csr_crmd_datm, csr_dmw0, csr_dmw1,
                      s_found, s_ppn, s_ps, s_plv, s_mat, s_d, s_v);
      xact(va, st, res, badv, lk, lat);
      n_tests++;
      if (res !== exp_res || badv !== va || lat !== 2 || lk !== {va[31:12], csr_asid}) begin
        n_fail++;
        $display("FAIL random[%0d]: got res=%h badv=%h lat=%0d lk=%h required res=%h badv=%h lat=2 lk=%h",
                 i, res, badv, lat, lk, exp_res, va, {va[31:12], csr_asid});
      end
    end
  endtask

  initial begin
    test_reset;
    test_da;
    test_dmw;
    test_tlb;
    test_exc_priority;
    test_backpressure_flush;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
